// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect inputs from execute, instruction-memory port and
// the fetched-instruction outputs toward decode.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [1:0]  pcsrc;
    logic [25:0] jaddr;
    logic [31:0] jr_addr;
    logic [15:0] br_imm;
    logic [31:0] br_npc;
    logic        halt;
    logic        stall;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] npc_out;

    modport master (
        input  redirect_valid, pcsrc, jaddr, jr_addr, br_imm, br_npc,
               halt, stall, ihit, imemload,
        output imemREN, imemaddr, instr_valid, instr_out, npc_out
    );

    modport slave (
        output redirect_valid, pcsrc, jaddr, jr_addr, br_imm, br_npc,
               halt, stall, ihit, imemload,
        input  imemREN, imemaddr, instr_valid, instr_out, npc_out
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, redirects from execute, drops an
// in-flight memory response after a redirect, and a sticky halt.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic CLK,
    input  logic nRST,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {FETCH, DROP, HALT} state_t;

    localparam logic [1:0] ADD4_DIAOSI   = 2'd0;
    localparam logic [1:0] JUMP_DIAOSI   = 2'd1;
    localparam logic [1:0] JR_DIAOSI     = 2'd2;
    localparam logic [1:0] BRANCH_DIAOSI = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic [31:0] npc_out_q, npc_out_d;

    logic        ren;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] br_off;

    assign redirect = bus.redirect_valid && (bus.pcsrc != ADD4_DIAOSI);
    assign br_off   = {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};

    always_comb begin
        target = pc_q;
        case (bus.pcsrc)
            JUMP_DIAOSI:   target = {bus.br_npc[31:28], bus.jaddr, 2'b00};
            JR_DIAOSI:     target = bus.jr_addr & 32'hFFFF_FFFC;
            BRANCH_DIAOSI: target = bus.br_npc + br_off;
            default:       target = pc_q;
        endcase
    end

    // Gated by nRST so no request escapes while the block is held in reset.
    always_comb begin
        ren = 1'b0;
        if (nRST) begin
            case (state_q)
                FETCH:   ren = !(instr_valid_q && bus.stall);
                DROP:    ren = 1'b1;
                default: ren = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        npc_out_d     = npc_out_q;

        if (!bus.stall) begin
            instr_valid_d = 1'b0;
        end

        if (bus.halt) begin
            state_d       = HALT;
            instr_valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        pc_d          = target;
                        instr_valid_d = 1'b0;
                        // Outstanding read must be drained before the new PC is issued.
                        if (ren && !bus.ihit) begin
                            req_addr_d = pc_q;
                            state_d    = DROP;
                        end
                    end else if (ren && bus.ihit) begin
                        instr_out_d   = bus.imemload;
                        npc_out_d     = pc_q + 32'd4;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc_d          = target;
                        instr_valid_d = 1'b0;
                    end
                    if (bus.ihit) begin
                        state_d = FETCH;
                    end
                end
                HALT: begin
                    instr_valid_d = 1'b0;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= FETCH;
            pc_q          <= PC_INIT;
            req_addr_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= 32'd0;
            npc_out_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            npc_out_q     <= npc_out_d;
        end
    end

    assign bus.imemREN     = ren;
    assign bus.imemaddr    = (state_q == DROP) ? req_addr_q : pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.npc_out     = npc_out_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirects through
// DROP, halt and reset during DROP, with hand-computed expectations.
module tb_fetch_unit;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   total = 0;
    int   bad = 0;

    fetch_unit_if bus();

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Memory model: each word is a distinct function of its address.
    always_comb bus.imemload = 32'hC0DE_0000 ^ bus.imemaddr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.pcsrc          = 2'd0;
        bus.jaddr          = 26'd0;
        bus.jr_addr        = 32'd0;
        bus.br_imm         = 16'd0;
        bus.br_npc         = 32'd0;
        bus.halt           = 1'b0;
        bus.stall          = 1'b0;
        bus.ihit           = 1'b0;

        repeat (2) tick();
        #1;
        check("rst_ren",   32'(bus.imemREN), 32'd0);
        check("rst_addr",  bus.imemaddr, 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr_out, 32'd0);
        check("rst_npc",   bus.npc_out, 32'd0);
        nRST = 1'b1;
        #1;
        check("rel_ren", 32'(bus.imemREN), 32'd1);

        // Back-to-back hits
        bus.ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", bus.imemaddr, 32'(4 * i));
            tick();
            check("seq_valid", 32'(bus.instr_valid), 32'd1);
            check("seq_instr", bus.instr_out, word(32'(4 * i)));
            check("seq_npc",   bus.npc_out, 32'(4 * i + 4));
        end

        // Stall with a valid instruction held
        bus.stall = 1'b1;
        #1;
        check("stall_ren", 32'(bus.imemREN), 32'd0);
        tick();
        check("stall_valid", 32'(bus.instr_valid), 32'd1);
        check("stall_instr", bus.instr_out, word(32'd8));
        check("stall_npc",   bus.npc_out, 32'd12);
        check("stall_addr",  bus.imemaddr, 32'd12);
        bus.stall = 1'b0;
        #1;
        check("resume_ren", 32'(bus.imemREN), 32'd1);
        tick();
        check("resume_instr", bus.instr_out, word(32'd12));
        check("resume_npc",   bus.npc_out, 32'd16);
        check("resume_addr",  bus.imemaddr, 32'd16);

        // Branch backwards with a same-cycle hit that must be discarded
        bus.pcsrc = 2'd3; bus.br_npc = 32'h104; bus.br_imm = 16'hFFFE;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        check("br_addr",  bus.imemaddr, 32'h0FC);
        check("br_valid", 32'(bus.instr_valid), 32'd0);

        // JR while the read is still outstanding
        bus.ihit = 1'b0;
        bus.pcsrc = 2'd2; bus.jr_addr = 32'h403;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        check("jr_hold_addr", bus.imemaddr, 32'h0FC);
        check("jr_hold_ren",  32'(bus.imemREN), 32'd1);
        tick();
        check("jr_hold2_addr", bus.imemaddr, 32'h0FC);
        bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        check("jr_addr",  bus.imemaddr, 32'h400);
        check("jr_valid", 32'(bus.instr_valid), 32'd0);

        // Second redirect arrives while already dropping
        bus.pcsrc = 2'd2; bus.jr_addr = 32'h600;
        bus.redirect_valid = 1'b1;
        tick();
        check("dr1_addr", bus.imemaddr, 32'h400);
        bus.pcsrc = 2'd3; bus.br_npc = 32'h1000; bus.br_imm = 16'h0004;
        tick();
        bus.redirect_valid = 1'b0;
        check("dr2_addr", bus.imemaddr, 32'h400);
        bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        check("dr_new_addr", bus.imemaddr, 32'h1010);

        // Halt wins over a same-cycle jump and hit
        bus.halt = 1'b1; bus.redirect_valid = 1'b1;
        bus.pcsrc = 2'd1; bus.jaddr = 26'h123; bus.br_npc = 32'h2000_0000;
        bus.ihit = 1'b1;
        tick();
        bus.halt = 1'b0; bus.redirect_valid = 1'b0;
        #1;
        check("halt_ren",   32'(bus.imemREN), 32'd0);
        check("halt_valid", 32'(bus.instr_valid), 32'd0);
        check("halt_addr",  bus.imemaddr, 32'h1010);
        repeat (3) tick();
        check("halt_sticky_ren",  32'(bus.imemREN), 32'd0);
        check("halt_sticky_addr", bus.imemaddr, 32'h1010);

        // Reset, one fetch, then reset again while in DROP
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        bus.ihit = 1'b0;
        bus.pcsrc = 2'd2; bus.jr_addr = 32'h800;
        bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        check("drop_addr", bus.imemaddr, 32'd4);
        #2 nRST = 1'b0;
        #1;
        check("rd_ren",   32'(bus.imemREN), 32'd0);
        check("rd_addr",  bus.imemaddr, 32'd0);
        check("rd_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        nRST = 1'b1;
        #1;
        check("rr_ren",  32'(bus.imemREN), 32'd1);
        check("rr_addr", bus.imemaddr, 32'd0);
        bus.ihit = 1'b1;
        tick();
        bus.ihit = 1'b0;
        check("rr_valid", 32'(bus.instr_valid), 32'd1);
        check("rr_instr", bus.instr_out, word(32'd0));
        check("rr_npc",   bus.npc_out, 32'd4);

        // JUMP with a same-cycle hit
        bus.pcsrc = 2'd1; bus.jaddr = 26'h40; bus.br_npc = 32'h3000_0000;
        bus.redirect_valid = 1'b1; bus.ihit = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        check("j_addr",  bus.imemaddr, 32'h3000_0100);
        check("j_valid", 32'(bus.instr_valid), 32'd0);

        // ADD4 redirect behaves as a plain fetch
        bus.pcsrc = 2'd0; bus.redirect_valid = 1'b1;
        tick();
        bus.redirect_valid = 1'b0; bus.ihit = 1'b0;
        check("a4_valid", 32'(bus.instr_valid), 32'd1);
        check("a4_instr", bus.instr_out, word(32'h3000_0100));
        check("a4_npc",   bus.npc_out, 32'h3000_0104);
        check("a4_addr",  bus.imemaddr, 32'h3000_0104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port redirect_valid  input  1  one-cycle request to load a new PC, from the execute stage.
REQ-005 SHALL have port pcsrc  input  2  PCSrc_t selector: ADD4_DIAOSI, JUMP_DIAOSI, JR_DIAOSI, BRANCH_DIAOSI.
REQ-006 SHALL have port jaddr  input  26  J-type instruction index.
REQ-007 SHALL have port jr_addr  input  32  register jump target (rs value).
REQ-008 SHALL have port br_imm  input  16  branch immediate.
REQ-009 SHALL have port br_npc  input  32  PC+4 of the redirecting instruction.
REQ-010 SHALL have port halt  input  1  stop fetching; sticky until reset.
REQ-011 SHALL have port stall  input  1  downstream (decode) cannot accept this cycle.
REQ-012 SHALL have port ihit  input  1  instruction memory response valid for imemaddr.
REQ-013 SHALL have port imemload  input  32  instruction word returned with ihit.
REQ-014 SHALL have port imemREN  output  1  instruction read request.
REQ-015 SHALL have port imemaddr  output  32  instruction read address.
REQ-016 SHALL have port instr_valid  output  1  instr_out/npc_out hold a valid fetched instruction.
REQ-017 SHALL have port instr_out  output  32  fetched instruction.
REQ-018 SHALL have port npc_out  output  32  fetch address + 4 of instr_out.

Function
REQ-019 SHALL implement states FETCH, DROP, HALT in a registered state machine.
REQ-020 SHALL keep a 32-bit pc register and a 32-bit req_addr register; imemaddr = pc in FETCH, req_addr in DROP.
REQ-021 SHALL assert imemREN in FETCH when not (instr_valid & stall), and always in DROP; deassert in HALT.
REQ-022 SHALL, in FETCH on ihit with imemREN=1 and no redirect/halt: instr_out<=imemload, npc_out<=pc+4, instr_valid<=1, pc<=pc+4.
REQ-023 SHALL clear instr_valid when stall=0 and no new instruction is captured that cycle; hold outputs unchanged while stall=1.
REQ-024 SHALL compute redirect target: JUMP -> {br_npc[31:28], jaddr, 2'b00}; JR -> {jr_addr[31:2], 2'b00}; BRANCH -> br_npc + (sign-extended br_imm << 2), modulo 2^32.
REQ-025 SHALL treat redirect_valid with pcsrc=ADD4_DIAOSI as a no-op.
REQ-026 SHALL, on a valid redirect: pc<=target, instr_valid<=0 (flush regardless of stall).
REQ-027 SHALL, on redirect in FETCH while imemREN=1 and ihit=0: req_addr<=pc and go to DROP.
REQ-028 SHALL, on redirect in FETCH with ihit=1 the same cycle: discard imemload, stay in FETCH.
REQ-029 SHALL, in DROP: hold req_addr until ihit, discard the response, then return to FETCH next cycle.
REQ-030 SHALL, on redirect while in DROP: update pc to the newest target, remain in DROP.
REQ-031 SHALL, on halt=1 in any state: enter HALT next cycle, clear instr_valid; halt overrides redirect and ihit the same cycle.
REQ-032 SHALL remain in HALT with pc frozen until nRST asserted.
REQ-033 SHALL have single-cycle issue latency: ihit in cycle N makes instr_valid=1 in cycle N+1.

Reset
REQ-034 SHALL, while nRST=0: pc=PC_INIT, req_addr=0, state=FETCH, instr_valid=0, instr_out=0, npc_out=0, imemREN=0.
REQ-035 SHALL, on nRST assertion mid-request or mid-DROP, abandon the request and restart at PC_INIT after release.

Verification
REQ-036 SHALL cover: reset release, ihit=1 every cycle -> imemaddr 0,4,8; instr_out follows imemload, npc_out 4,8,12.
REQ-037 SHALL cover: stall=1 with instr_valid=1 -> imemREN=0, outputs frozen; stall=0 -> fetch resumes at next pc.
REQ-038 SHALL cover: BRANCH redirect, br_npc=0x104, br_imm=0xFFFE -> pc=0x0FC, instr_valid=0 next cycle.
REQ-039 SHALL cover: JR redirect to 0x403 while ihit=0 -> DROP, old addr held until ihit, then imemaddr=0x400.
REQ-040 SHALL cover: halt and JUMP redirect same cycle -> HALT, imemREN=0, pc unchanged thereafter.
REQ-041 SHALL cover: nRST pulsed during DROP -> state FETCH, imemaddr=PC_INIT, instr_valid=0.
